// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the write-back direct-mapped data cache
package dcache_pkg;

    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    // Line array write-port operation; one per cycle.
    typedef enum logic [1:0] {
        LA_NONE  = 2'd0,
        LA_WORD  = 2'd1,
        LA_CLEAN = 2'd2,
        LA_FILL  = 2'd3
    } la_op_t;

endpackage

// File: rtl/dcache_wb_dm_if.sv
// rtl/dcache_wb_dm_if.sv - core-side request port and line-wide memory port of the data cache
interface dcache_wb_dm_if;

    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    // master: the environment (core plus memory); slave: the cache itself.
    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - valid/dirty/tag/data storage, combinational read, one write port
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int LINE_NUM = 8,
    parameter int IDX_W    = $clog2(LINE_NUM),
    parameter int TAG_W    = 28 - IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  la_op_t            wr_op,
    input  logic [1:0]        wr_word,
    input  logic [WORD_W-1:0] wr_wdata,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line
);

    logic [LINE_NUM-1:0] valid_q;
    logic [LINE_NUM-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [LINE_NUM];
    logic [LINE_W-1:0]   data_q [LINE_NUM];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (wr_op)
                LA_WORD:  dirty_q[idx] <= 1'b1;
                LA_CLEAN: dirty_q[idx] <= 1'b0;
                LA_FILL: begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Payload is not reset; a write landing during reset is harmless since valid is cleared.
    always_ff @(posedge clk) begin
        case (wr_op)
            LA_WORD: data_q[idx][32'(wr_word) * WORD_W +: WORD_W] <= wr_wdata;
            LA_FILL: begin
                data_q[idx] <= wr_line;
                tag_q[idx]  <= wr_tag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dcache_wb_dm.sv
// rtl/dcache_wb_dm.sv - direct-mapped write-back write-allocate data cache; DCACHE_PERF_EN adds hit/miss counters
module dcache_wb_dm
    import dcache_pkg::*;
#(
    parameter  int LINE_NUM = 8,
    localparam int IDX_W    = $clog2(LINE_NUM),
    localparam int TAG_W    = 28 - IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef DCACHE_PERF_EN
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt,
`endif
    dcache_wb_dm_if.slave bus
);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [1:0]          word;
    logic                ln_valid;
    logic                ln_dirty;
    logic [TAG_W-1:0]    ln_tag;
    logic [LINE_W-1:0]   ln_data;
    logic [WORD_W-1:0]   sel_word;
    la_op_t              wr_op;
    logic                req;
    logic                idle_hit;
    logic                rd_done;
    logic                wr_done;
    logic                miss;
    logic                post_fill;
    logic [WORD_W-1:0]   rdata_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [27:0]         mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q;

    assign idx      = bus.proc_addr[IDX_W+1:2];
    assign tag      = bus.proc_addr[29:IDX_W+2];
    assign word     = bus.proc_addr[1:0];
    assign sel_word = ln_data[32'(word) * WORD_W +: WORD_W];

    // A simultaneous read and write is a write.
    assign req      = bus.proc_read | bus.proc_write;
    assign idle_hit = (state == IDLE) && req && ln_valid && (ln_tag == tag);
    assign rd_done  = idle_hit && !bus.proc_write;
    assign wr_done  = idle_hit && bus.proc_write;
    assign miss     = (state == IDLE) && req && !(ln_valid && (ln_tag == tag));

    always_comb begin
        wr_op = LA_NONE;
        if (wr_done)
            wr_op = LA_WORD;
        else if (state == WRITEBACK && bus.mem_ready)
            wr_op = LA_CLEAN;
        else if (state == ALLOCATE && bus.mem_ready)
            wr_op = LA_FILL;
    end

    dcache_line_array #(
        .LINE_NUM (LINE_NUM),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx      (idx),
        .rd_valid (ln_valid),
        .rd_dirty (ln_dirty),
        .rd_tag   (ln_tag),
        .rd_data  (ln_data),
        .wr_op    (wr_op),
        .wr_word  (word),
        .wr_wdata (bus.proc_wdata),
        .wr_tag   (tag),
        .wr_line  (bus.mem_rdata)
    );

    assign bus.proc_stall = (state != IDLE) || miss;
    assign bus.proc_rdata = rd_done ? sel_word : rdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rdata_q     <= '0;
            post_fill   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            post_fill <= 1'b0;
            if (rd_done)
                rdata_q <= sel_word;
            case (state)
                IDLE: begin
                    if (miss) begin
                        if (ln_valid && ln_dirty) begin
                            state       <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {ln_tag, idx};
                            mem_wdata_q <= ln_data;
                        end else begin
                            state      <= ALLOCATE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= bus.proc_addr[29:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        state       <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= bus.proc_addr[29:2];
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        state      <= IDLE;
                        mem_read_q <= 1'b0;
                        post_fill  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_EN
    // The completion cycle right after a fill belongs to the miss, not a hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (idle_hit && !post_fill)
                hit_cnt <= hit_cnt + 32'd1;
            if (miss)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wb_dm.sv
// tb/tb_dcache_wb_dm.sv - directed plus randomized self-checking bench for dcache_wb_dm
module tb_dcache_wb_dm;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   exp_hits;
    int   exp_misses;

    logic [127:0] mem_arr  [64];
    logic [31:0]  ref_word [256];
    logic         res_valid [8];
    logic         res_dirty [8];
    int           res_line  [8];

    dcache_wb_dm_if bus ();

`ifdef DCACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_wb_dm dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef DCACHE_PERF_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural view after reset: whatever memory holds.
    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
            res_line[i]  = 0;
        end
        for (int a = 0; a < 256; a++)
            ref_word[a] = mem_arr[a / 4][(a % 4) * 32 +: 32];
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic access(input logic wr, input logic both, input int a, input logic [31:0] d,
                          input int dly, input logic stray);
        int           line;
        int           ix;
        logic         exp_hit;
        logic         eff_wr;
        logic [127:0] vline;
        line   = a / 4;
        ix     = line % 8;
        eff_wr = wr | both;
        @(negedge clk);
        bus.proc_read  = !wr | both;
        bus.proc_write = eff_wr;
        bus.proc_addr  = 30'(a);
        bus.proc_wdata = d;
        bus.mem_ready  = 1'b0;
        #1;
        exp_hit = res_valid[ix] && (res_line[ix] == line);
        chk("stall_first", bus.proc_stall, !exp_hit);
        chk("mem_idle", {bus.mem_read, bus.mem_write}, 2'b00);
        if (exp_hit) begin
            exp_hits++;
            if (stray) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end else begin
            exp_misses++;
            if (res_valid[ix] && res_dirty[ix]) begin
                for (int k = 0; k < 4; k++)
                    vline[k * 32 +: 32] = ref_word[res_line[ix] * 4 + k];
                for (int c = 0; c <= dly; c++) begin
                    @(negedge clk);
                    bus.mem_ready = 1'b0;
                    #1;
                    chk("wb_rw", {bus.mem_read, bus.mem_write}, 2'b01);
                    chk("wb_addr", bus.mem_addr, 128'(res_line[ix]));
                    chk("wb_data", bus.mem_wdata, vline);
                    chk("wb_stall", bus.proc_stall, 1'b1);
                    if (c == dly) begin
                        bus.mem_ready = 1'b1;
                        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    end
                end
                mem_arr[res_line[ix]] = vline;
            end
            for (int c = 0; c <= dly; c++) begin
                @(negedge clk);
                bus.mem_ready = 1'b0;
                #1;
                chk("al_rw", {bus.mem_read, bus.mem_write}, 2'b10);
                chk("al_addr", bus.mem_addr, 128'(line));
                chk("al_stall", bus.proc_stall, 1'b1);
                if (c == dly) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_arr[line];
                end
            end
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            chk("done_stall", bus.proc_stall, 1'b0);
            chk("done_mem", {bus.mem_read, bus.mem_write}, 2'b00);
            res_valid[ix] = 1'b1;
            res_dirty[ix] = 1'b0;
            res_line[ix]  = line;
        end
        if (eff_wr) begin
            ref_word[a]   = d;
            res_dirty[ix] = 1'b1;
        end else begin
            chk("rdata", bus.proc_rdata, ref_word[a]);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        for (int i = 0; i < 64; i++)
            mem_arr[i] = {$urandom, $urandom, $urandom, $urandom};
        mem_arr[0] = 128'h44444444_33333333_22222222_11111111;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_stall", bus.proc_stall, 1'b0);
        chk("rst_rdata", bus.proc_rdata, 32'h0);
        chk("rst_mem_rw", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("rst_mem_addr", bus.mem_addr, 28'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 128'h0);
`ifdef DCACHE_PERF_EN
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif

        // Directed: cold miss, hit, store hit, conflicting dirty eviction.
        access(1'b0, 1'b0, 'h02, 32'h0, 2, 1'b0);
        chk("dir_fill_word", bus.proc_rdata, 32'h33333333);
        access(1'b0, 1'b0, 'h03, 32'h0, 0, 1'b0);
        chk("dir_hit_word", bus.proc_rdata, 32'h44444444);
        access(1'b1, 1'b0, 'h01, 32'hDEADBEEF, 0, 1'b0);
        access(1'b0, 1'b0, 'h01, 32'h0, 0, 1'b0);
        chk("dir_store_word", bus.proc_rdata, 32'hDEADBEEF);
        access(1'b0, 1'b0, 'h20, 32'h0, 1, 1'b0);
        chk("dir_victim_mem", mem_arr[0], 128'h44444444_33333333_DEADBEEF_11111111);
`ifdef DCACHE_PERF_EN
        chk("dir_hit_cnt", hit_cnt, 32'd3);
        chk("dir_miss_cnt", miss_cnt, 32'd2);
`endif

        // Reset in ALLOCATE with a memory response arriving in the same cycle.
        @(negedge clk);
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = 30'h40;
        #1;
        chk("rm_stall", bus.proc_stall, 1'b1);
        @(negedge clk);
        #1;
        chk("rm_alloc_rw", {bus.mem_read, bus.mem_write}, 2'b10);
        chk("rm_alloc_addr", bus.mem_addr, 28'h10);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.proc_read = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_arr[16];
        @(negedge clk);
        rst_n         = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        chk("rm_mem_read", bus.mem_read, 1'b0);
        chk("rm_mem_write", bus.mem_write, 1'b0);
        chk("rm_stall_after", bus.proc_stall, 1'b0);
        chk("rm_rdata", bus.proc_rdata, 32'h0);
        model_reset();
        access(1'b0, 1'b0, 'h20, 32'h0, 0, 1'b0);
        access(1'b0, 1'b0, 'h40, 32'h0, 0, 1'b0);

        // Randomized traffic against the architectural word-memory model.
        for (int n = 0; n < 300; n++) begin
            access(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                   int'($urandom_range(0, 255)), $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
`ifdef DCACHE_PERF_EN
        chk("rnd_hit_cnt", hit_cnt, 32'(exp_hits));
        chk("rnd_miss_cnt", miss_cnt, 32'(exp_misses));
`endif

        // Read back every word; dirty lines are evicted along the way.
        for (int a = 0; a < 256; a++)
            access(1'b0, 1'b0, a, 32'h0, 0, 1'b0);

        @(negedge clk);
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
